jam_gen: RTL and testbench

- Parametrised exhaustive job-assignment solver for N workers and N jobs.
- Enumerates all N! permutations in lexicographic order using next-permutation stepping.
- Reads each worker/job cost from an external combinational cost table.
- Reports the minimum total cost, the number of permutations that achieve it, and the first (lexicographically smallest) optimal assignment.
- Adds over the previous generation: start/busy handshake, restart without reset, configurable N and cost width, and output of the best permutation.

---
 rtl/jam_gen.sv | 189 ++++++++++++++++++
 tb/tb_jam_gen.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jam_gen.sv
// Exhaustive N x N job-assignment solver: walks all permutations in lexicographic
// order, prunes partial sums that already exceed the best total, and reports the optimum.
module jam_gen #(
  parameter int N      = 8,
  parameter int IDX_W  = 3,
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start,
  output logic [IDX_W-1:0]     W,
  output logic [IDX_W-1:0]     J,
  input  logic [COST_W-1:0]    Cost,
  output logic                 Busy,
  output logic                 Valid,
  output logic [SUM_W-1:0]     MinCost,
  output logic [CNT_W-1:0]     MatchCount,
  output logic [N*IDX_W-1:0]   BestPerm
);

  typedef enum logic [2:0] {
    S_IDLE, S_BEGIN, S_CALC, S_FIND_I, S_FIND_J, S_SWAP, S_REVERSE, S_DONE
  } state_t;

  typedef logic [N-1:0][IDX_W-1:0] perm_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] PIVOT0   = IDX_W'(N - 2);

  function automatic perm_t identity_perm();
    perm_t p;
    for (int w = 0; w < N; w++) p[w] = IDX_W'(w);
    return p;
  endfunction

  state_t            state_r, state_s;
  logic [IDX_W-1:0]  i_r, i_s, j_r, j_s, k_r, k_s, lo_r, lo_s, hi_r, hi_s;
  logic [SUM_W-1:0]  sum_r, sum_s, min_r, min_s, calc_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  perm_t             perm_r, perm_s, best_r, best_s;
  logic              busy_r, busy_s, valid_r, valid_s;

  assign calc_s     = sum_r + SUM_W'(Cost);
  assign W          = i_r;
  assign J          = perm_r[i_r];
  assign Busy       = busy_r;
  assign Valid      = valid_r;
  assign MinCost    = min_r;
  assign MatchCount = cnt_r;
  assign BestPerm   = best_r;

  // State and datapath register bank
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= S_IDLE;
      i_r     <= '0;
      j_r     <= '0;
      k_r     <= '0;
      lo_r    <= '0;
      hi_r    <= '0;
      sum_r   <= '0;
      min_r   <= '1;
      cnt_r   <= '0;
      perm_r  <= identity_perm();
      best_r  <= identity_perm();
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      i_r     <= i_s;
      j_r     <= j_s;
      k_r     <= k_s;
      lo_r    <= lo_s;
      hi_r    <= hi_s;
      sum_r   <= sum_s;
      min_r   <= min_s;
      cnt_r   <= cnt_s;
      perm_r  <= perm_s;
      best_r  <= best_s;
      busy_r  <= busy_s;
      valid_r <= valid_s;
    end
  end

  // Next-state, permutation stepping and result update
  always_comb begin
    state_s = state_r;
    i_s     = i_r;
    j_s     = j_r;
    k_s     = k_r;
    lo_s    = lo_r;
    hi_s    = hi_r;
    sum_s   = sum_r;
    min_s   = min_r;
    cnt_s   = cnt_r;
    perm_s  = perm_r;
    best_s  = best_r;
    busy_s  = busy_r;
    valid_s = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (Start) begin
          perm_s  = identity_perm();
          best_s  = identity_perm();
          min_s   = '1;
          cnt_s   = '0;
          busy_s  = 1'b1;
          state_s = S_BEGIN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_BEGIN: begin
        i_s     = '0;
        sum_s   = '0;
        state_s = S_CALC;
      end
      S_CALC: begin
        // Only a complete, unpruned permutation can touch the results
        if (i_r == LAST_IDX && calc_s < min_r) begin
          min_s  = calc_s;
          cnt_s  = CNT_W'(1);
          best_s = perm_r;
        end else if (i_r == LAST_IDX && calc_s == min_r) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
        if (calc_s > min_r || i_r == LAST_IDX) begin
          i_s     = PIVOT0;
          state_s = S_FIND_I;
        end else begin
          i_s   = i_r + IDX_W'(1);
          sum_s = calc_s;
        end
      end
      S_FIND_I: begin
        if (perm_r[i_r + IDX_W'(1)] > perm_r[i_r]) begin
          j_s     = i_r + IDX_W'(1);
          k_s     = i_r + IDX_W'(1);
          state_s = S_FIND_J;
        end else if (i_r == '0) begin
          busy_s  = 1'b0;
          valid_s = 1'b1;
          state_s = S_DONE;
        end else begin
          i_s = i_r - IDX_W'(1);
        end
      end
      S_FIND_J: begin
        // k tracks the smallest suffix element still larger than the pivot
        if (perm_r[j_r] > perm_r[i_r] && perm_r[j_r] < perm_r[k_r]) begin
          k_s = j_r;
        end else begin
          k_s = k_r;
        end
        if (j_r == LAST_IDX) begin
          state_s = S_SWAP;
        end else begin
          j_s = j_r + IDX_W'(1);
        end
      end
      S_SWAP: begin
        perm_s[i_r] = perm_r[k_r];
        perm_s[k_r] = perm_r[i_r];
        lo_s        = i_r + IDX_W'(1);
        hi_s        = LAST_IDX;
        state_s     = S_REVERSE;
      end
      S_REVERSE: begin
        if (lo_r < hi_r) begin
          perm_s[lo_r] = perm_r[hi_r];
          perm_s[hi_r] = perm_r[lo_r];
          lo_s         = lo_r + IDX_W'(1);
          hi_s         = hi_r - IDX_W'(1);
        end else begin
          state_s = S_BEGIN;
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_jam_gen.sv
// Self-checking bench for jam_gen: three instances (N=4, N=3, N=6), table-driven searches
// checked by a scoreboard against a brute-force tuple enumeration, plus restart/reset sequences.
module tb_jam_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_a, busy_a, valid_a;
  logic [1:0] w_a, j_a;
  logic [6:0] cost_a;
  logic [9:0] min_a;
  logic [15:0] cnt_a;
  logic [7:0] perm_a;

  logic       start_b, busy_b, valid_b;
  logic [1:0] w_b, j_b;
  logic [6:0] cost_b;
  logic [9:0] min_b;
  logic [15:0] cnt_b;
  logic [5:0] perm_b;

  logic       start_c, busy_c, valid_c;
  logic [2:0] w_c, j_c;
  logic [6:0] cost_c;
  logic [9:0] min_c;
  logic [15:0] cnt_c;
  logic [17:0] perm_c;

  logic [6:0] ctab [3][8][8];

  assign cost_a = ctab[0][{1'b0, w_a}][{1'b0, j_a}];
  assign cost_b = ctab[1][{1'b0, w_b}][{1'b0, j_b}];
  assign cost_c = ctab[2][w_c][j_c];

  jam_gen #(.N(4), .IDX_W(2), .COST_W(7), .SUM_W(10), .CNT_W(16)) dut_a (
    .CLK(clk), .RST(rst_n), .Start(start_a), .W(w_a), .J(j_a), .Cost(cost_a),
    .Busy(busy_a), .Valid(valid_a), .MinCost(min_a), .MatchCount(cnt_a), .BestPerm(perm_a));

  jam_gen #(.N(3), .IDX_W(2), .COST_W(7), .SUM_W(10), .CNT_W(16)) dut_b (
    .CLK(clk), .RST(rst_n), .Start(start_b), .W(w_b), .J(j_b), .Cost(cost_b),
    .Busy(busy_b), .Valid(valid_b), .MinCost(min_b), .MatchCount(cnt_b), .BestPerm(perm_b));

  jam_gen #(.N(6), .IDX_W(3), .COST_W(7), .SUM_W(10), .CNT_W(16)) dut_c (
    .CLK(clk), .RST(rst_n), .Start(start_c), .W(w_c), .J(j_c), .Cost(cost_c),
    .Busy(busy_c), .Valid(valid_c), .MinCost(min_c), .MatchCount(cnt_c), .BestPerm(perm_c));

  typedef struct {
    int          sel;
    logic [47:0] minc;
    logic [47:0] cnt;
    logic [47:0] perm;
  } exp_t;

  typedef struct {
    int          sel;
    int          mode;
    bit          use_model;
    logic [47:0] minc;
    logic [47:0] cnt;
    logic [47:0] perm;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int n_of(input int s);
    return (s == 0) ? 4 : ((s == 1) ? 3 : 6);
  endfunction

  function automatic int iw_of(input int s);
    return (s == 2) ? 3 : 2;
  endfunction

  function automatic logic [47:0] valid_of(input int s);
    case (s)
      0: return 48'(valid_a);
      1: return 48'(valid_b);
      default: return 48'(valid_c);
    endcase
  endfunction

  function automatic logic [47:0] busy_of(input int s);
    case (s)
      0: return 48'(busy_a);
      1: return 48'(busy_b);
      default: return 48'(busy_c);
    endcase
  endfunction

  function automatic logic [47:0] min_of(input int s);
    case (s)
      0: return 48'(min_a);
      1: return 48'(min_b);
      default: return 48'(min_c);
    endcase
  endfunction

  function automatic logic [47:0] cnt_of(input int s);
    case (s)
      0: return 48'(cnt_a);
      1: return 48'(cnt_b);
      default: return 48'(cnt_c);
    endcase
  endfunction

  function automatic logic [47:0] perm_of(input int s);
    case (s)
      0: return 48'(perm_a);
      1: return 48'(perm_b);
      default: return 48'(perm_c);
    endcase
  endfunction

  task automatic set_start(input int s, input logic v);
    case (s)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic fill_table(input int s, input int mode);
    int n;
    n = n_of(s);
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 8; j++) begin
        case (mode)
          0: ctab[s][w][j] = 7'd5;
          1: ctab[s][w][j] = (j == n - 1 - w) ? 7'd0 : 7'd9;
          2: ctab[s][w][j] = 7'((w * j) % 17);
          3: ctab[s][w][j] = 7'd127;
          default: ctab[s][w][j] = 7'($urandom_range(0, 127));
        endcase
      end
    end
  endtask

  // Brute force over all n^n tuples (worker 0 most significant), keeping only permutations
  task automatic model(input int s, output exp_t e);
    int n, iw, total, rem, used, sum, best;
    int d[8];
    bit ok;
    logic [47:0] pk;
    n = n_of(s);
    iw = iw_of(s);
    total = 1;
    for (int q = 0; q < n; q++) total = total * n;
    best = 32'h7fffffff;
    e.sel = s;
    e.cnt = 48'd0;
    e.perm = 48'd0;
    for (int c = 0; c < total; c++) begin
      rem = c;
      for (int w = n - 1; w >= 0; w--) begin
        d[w] = rem % n;
        rem = rem / n;
      end
      used = 0;
      ok = 1'b1;
      sum = 0;
      pk = 48'd0;
      for (int w = 0; w < n; w++) begin
        if (used[d[w]]) ok = 1'b0;
        used = used | (1 << d[w]);
        sum = sum + int'(ctab[s][w][d[w]]);
        pk = pk | (48'(d[w]) << (w * iw));
      end
      if (ok && sum < best) begin
        best = sum;
        e.cnt = 48'd1;
        e.perm = pk;
      end else if (ok && sum == best) begin
        e.cnt = e.cnt + 48'd1;
      end
    end
    e.minc = 48'(best);
  endtask

  task automatic start_search(input int s, input exp_t e);
    sb.push_back(e);
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    check("busy_rise", busy_of(s), 48'd1);
  endtask

  task automatic wait_valid(input int s, input int budget, input bit spam);
    int cyc;
    cyc = 0;
    while (valid_of(s) == 48'd0 && cyc < budget) begin
      set_start(s, spam && (cyc % 5 == 2));
      @(posedge clk); #1;
      cyc++;
    end
    set_start(s, 1'b0);
    check("valid_seen", valid_of(s), 48'd1);
    check("busy_low_on_valid", busy_of(s), 48'd0);
  endtask

  task automatic post_valid(input int s);
    @(posedge clk); #1;
    check("valid_one_cycle", valid_of(s), 48'd0);
    check("busy_low_after", busy_of(s), 48'd0);
    check("sb_drained", 48'(sb.size()), 48'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_busy_a", 48'(busy_a), 48'd0);
    check("rst_valid_a", 48'(valid_a), 48'd0);
    check("rst_min_a", 48'(min_a), 48'd1023);
    check("rst_cnt_a", 48'(cnt_a), 48'd0);
    check("rst_perm_a", 48'(perm_a), 48'hE4);
    check("rst_w_a", 48'(w_a), 48'd0);
    check("rst_j_a", 48'(j_a), 48'd0);
    check("rst_perm_b", 48'(perm_b), 48'h24);
    check("rst_perm_c", 48'(perm_c), 48'h2C688);
    check("rst_min_c", 48'(min_c), 48'd1023);
  endtask

  // Scoreboard: every Valid pulse consumes exactly one expected result
  always @(negedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < 3; s++) begin
        if (valid_of(s) == 48'd1) begin
          if (sb.size() == 0) begin
            check("unexpected_valid", valid_of(s), 48'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_instance", 48'(s), 48'(e.sel));
            check("min_cost", min_of(s), e.minc);
            check("match_count", cnt_of(s), e.cnt);
            check("best_perm", perm_of(s), e.perm);
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    int cyc;
    vecs[0] = '{sel: 0, mode: 0, use_model: 1'b0, minc: 48'd20,  cnt: 48'd24,  perm: 48'hE4};
    vecs[1] = '{sel: 1, mode: 1, use_model: 1'b0, minc: 48'd0,   cnt: 48'd1,   perm: 48'h06};
    vecs[2] = '{sel: 0, mode: 1, use_model: 1'b0, minc: 48'd0,   cnt: 48'd1,   perm: 48'h1B};
    vecs[3] = '{sel: 2, mode: 2, use_model: 1'b1, minc: 48'd0,   cnt: 48'd0,   perm: 48'd0};
    vecs[4] = '{sel: 2, mode: 3, use_model: 1'b0, minc: 48'd762, cnt: 48'd720, perm: 48'h2C688};
    vecs[5] = '{sel: 0, mode: 4, use_model: 1'b1, minc: 48'd0,   cnt: 48'd0,   perm: 48'd0};

    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    for (int s = 0; s < 3; s++) fill_table(s, 0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Main table; vector 2 also pulses Start repeatedly while busy
    for (int v = 0; v < 6; v++) begin
      fill_table(vecs[v].sel, vecs[v].mode);
      if (vecs[v].use_model) begin
        model(vecs[v].sel, e);
      end else begin
        e = '{sel: vecs[v].sel, minc: vecs[v].minc, cnt: vecs[v].cnt, perm: vecs[v].perm};
      end
      start_search(vecs[v].sel, e);
      wait_valid(vecs[v].sel, 30000, v == 2);
      post_valid(vecs[v].sel);
    end

    // Start in the Valid cycle: results clear, then the same result repeats
    fill_table(0, 4);
    model(0, e);
    start_search(0, e);
    wait_valid(0, 2000, 1'b0);
    sb.push_back(e);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("restart_cnt_clear", 48'(cnt_a), 48'd0);
    check("restart_min_clear", 48'(min_a), 48'd1023);
    check("restart_busy", 48'(busy_a), 48'd1);
    check("restart_valid_low", 48'(valid_a), 48'd0);
    wait_valid(0, 2000, 1'b0);
    post_valid(0);

    // Asynchronous reset in the middle of a search, then an uninterrupted rerun
    start_search(0, e);
    cyc = 0;
    while (!(w_a == 2'd2 && busy_a) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mid_calc_reached", 48'(w_a), 48'd2);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("idle_after_abort", 48'(busy_a), 48'd0);
    start_search(0, e);
    wait_valid(0, 2000, 1'b0);
    post_valid(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
